// File: rtl/core_inst_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: command op codes,
// base opcodes, funct3/funct7 values and the LI sequencing state type.
package core_inst_encoder_pkg;

    localparam int unsigned CORE_ENC_OP_W = 6;

    localparam logic [5:0] CORE_ENC_OP_LUI     = 6'd0;
    localparam logic [5:0] CORE_ENC_OP_AUIPC   = 6'd1;
    localparam logic [5:0] CORE_ENC_OP_JAL     = 6'd2;
    localparam logic [5:0] CORE_ENC_OP_JALR    = 6'd3;
    localparam logic [5:0] CORE_ENC_OP_BEQ     = 6'd4;
    localparam logic [5:0] CORE_ENC_OP_BNE     = 6'd5;
    localparam logic [5:0] CORE_ENC_OP_BLT     = 6'd6;
    localparam logic [5:0] CORE_ENC_OP_BGE     = 6'd7;
    localparam logic [5:0] CORE_ENC_OP_BLTU    = 6'd8;
    localparam logic [5:0] CORE_ENC_OP_BGEU    = 6'd9;
    localparam logic [5:0] CORE_ENC_OP_LB      = 6'd10;
    localparam logic [5:0] CORE_ENC_OP_LH      = 6'd11;
    localparam logic [5:0] CORE_ENC_OP_LW      = 6'd12;
    localparam logic [5:0] CORE_ENC_OP_LBU     = 6'd13;
    localparam logic [5:0] CORE_ENC_OP_LHU     = 6'd14;
    localparam logic [5:0] CORE_ENC_OP_SB      = 6'd15;
    localparam logic [5:0] CORE_ENC_OP_SH      = 6'd16;
    localparam logic [5:0] CORE_ENC_OP_SW      = 6'd17;
    localparam logic [5:0] CORE_ENC_OP_ADDI    = 6'd18;
    localparam logic [5:0] CORE_ENC_OP_SLTI    = 6'd19;
    localparam logic [5:0] CORE_ENC_OP_SLTIU   = 6'd20;
    localparam logic [5:0] CORE_ENC_OP_XORI    = 6'd21;
    localparam logic [5:0] CORE_ENC_OP_ORI     = 6'd22;
    localparam logic [5:0] CORE_ENC_OP_ANDI    = 6'd23;
    localparam logic [5:0] CORE_ENC_OP_SLLI    = 6'd24;
    localparam logic [5:0] CORE_ENC_OP_SRLI    = 6'd25;
    localparam logic [5:0] CORE_ENC_OP_SRAI    = 6'd26;
    localparam logic [5:0] CORE_ENC_OP_ADD     = 6'd27;
    localparam logic [5:0] CORE_ENC_OP_SUB     = 6'd28;
    localparam logic [5:0] CORE_ENC_OP_SLL     = 6'd29;
    localparam logic [5:0] CORE_ENC_OP_SLT     = 6'd30;
    localparam logic [5:0] CORE_ENC_OP_SLTU    = 6'd31;
    localparam logic [5:0] CORE_ENC_OP_XOR     = 6'd32;
    localparam logic [5:0] CORE_ENC_OP_SRL     = 6'd33;
    localparam logic [5:0] CORE_ENC_OP_SRA     = 6'd34;
    localparam logic [5:0] CORE_ENC_OP_OR      = 6'd35;
    localparam logic [5:0] CORE_ENC_OP_AND     = 6'd36;
    localparam logic [5:0] CORE_ENC_OP_FENCE   = 6'd37;
    localparam logic [5:0] CORE_ENC_OP_FENCE_I = 6'd38;
    localparam logic [5:0] CORE_ENC_OP_ECALL   = 6'd39;
    localparam logic [5:0] CORE_ENC_OP_EBREAK  = 6'd40;
    localparam logic [5:0] CORE_ENC_OP_CSRRW   = 6'd41;
    localparam logic [5:0] CORE_ENC_OP_CSRRS   = 6'd42;
    localparam logic [5:0] CORE_ENC_OP_CSRRC   = 6'd43;
    localparam logic [5:0] CORE_ENC_OP_CSRRWI  = 6'd44;
    localparam logic [5:0] CORE_ENC_OP_CSRRSI  = 6'd45;
    localparam logic [5:0] CORE_ENC_OP_CSRRCI  = 6'd46;
    localparam logic [5:0] CORE_ENC_OP_LI      = 6'd47;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_000 = 3'b000;
    localparam logic [2:0] F3_001 = 3'b001;
    localparam logic [2:0] F3_010 = 3'b010;
    localparam logic [2:0] F3_011 = 3'b011;
    localparam logic [2:0] F3_100 = 3'b100;
    localparam logic [2:0] F3_101 = 3'b101;
    localparam logic [2:0] F3_110 = 3'b110;
    localparam logic [2:0] F3_111 = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    localparam int unsigned ENC_WORD_W = 33;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_LI_LO = 1'b1
    } enc_state_e;

endpackage

// File: rtl/core_inst_enc_fifo.sv
// Small word FIFO for encoded instructions; head entry is driven straight
// from the storage flops so the output never depends on same-cycle inputs.
module core_inst_enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign data  = mem[rd_ptr[AW-1:0]];

    // Storage and pointer update; pointers carry one extra wrap bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && !valid));

endmodule

// File: rtl/core_inst_encoder.sv
// RV32I instruction encoder for the debug instruction-injection path.
// Optional feature macro: CORE_INST_ENC_LI_EN builds the LI pseudo-op
// (LUI+ADDI sequencing through the LI_LO state).
module core_inst_encoder
    import core_inst_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [CORE_ENC_OP_W-1:0] i_cmd_op,
    input  logic [4:0]               i_cmd_rd,
    input  logic [4:0]               i_cmd_rs1,
    input  logic [4:0]               i_cmd_rs2,
    input  logic [31:0]              i_cmd_imm,
    output logic                     o_inst_valid,
    input  logic                     i_inst_ready,
    output logic [31:0]              o_inst,
    output logic                     o_inst_err
);

    logic                  fifo_full;
    logic                  cmd_fire;
    logic                  push;
    logic [ENC_WORD_W-1:0] push_word;
    logic [ENC_WORD_W-1:0] head;
    logic                  pop;

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [24:0] i_fields;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic        imm_i_ok;
    logic        imm_b_ok;
    logic        imm_j_ok;
    logic        imm_u_ok;
    logic        imm_sh_ok;

    // Immediate range checks per instruction format.
    assign imm_i_ok  = (&i_cmd_imm[31:11]) | ~(|i_cmd_imm[31:11]);
    assign imm_b_ok  = ((&i_cmd_imm[31:12]) | ~(|i_cmd_imm[31:12])) & ~i_cmd_imm[0];
    assign imm_j_ok  = ((&i_cmd_imm[31:20]) | ~(|i_cmd_imm[31:20])) & ~i_cmd_imm[0];
    assign imm_u_ok  = ~(|i_cmd_imm[11:0]);
    assign imm_sh_ok = ~(|i_cmd_imm[31:5]);

    assign i_fields = {i_cmd_imm[11:0], i_cmd_rs1, f3, i_cmd_rd};

    // funct3/funct7 selection shared by all formats.
    always_comb begin
        f3 = F3_000;
        f7 = F7_BASE;
        case (i_cmd_op)
            CORE_ENC_OP_BNE, CORE_ENC_OP_LH, CORE_ENC_OP_SH, CORE_ENC_OP_SLLI,
            CORE_ENC_OP_SLL, CORE_ENC_OP_CSRRW, CORE_ENC_OP_FENCE_I:        f3 = F3_001;
            CORE_ENC_OP_LW, CORE_ENC_OP_SW, CORE_ENC_OP_SLTI, CORE_ENC_OP_SLT,
            CORE_ENC_OP_CSRRS:                                              f3 = F3_010;
            CORE_ENC_OP_SLTIU, CORE_ENC_OP_SLTU, CORE_ENC_OP_CSRRC:         f3 = F3_011;
            CORE_ENC_OP_BLT, CORE_ENC_OP_LBU, CORE_ENC_OP_XORI,
            CORE_ENC_OP_XOR:                                                f3 = F3_100;
            CORE_ENC_OP_BGE, CORE_ENC_OP_LHU, CORE_ENC_OP_SRLI, CORE_ENC_OP_SRL,
            CORE_ENC_OP_CSRRWI:                                             f3 = F3_101;
            CORE_ENC_OP_SRAI, CORE_ENC_OP_SRA: begin
                f3 = F3_101;
                f7 = F7_ALT;
            end
            CORE_ENC_OP_SUB:                                                f7 = F7_ALT;
            CORE_ENC_OP_BLTU, CORE_ENC_OP_ORI, CORE_ENC_OP_OR,
            CORE_ENC_OP_CSRRSI:                                             f3 = F3_110;
            CORE_ENC_OP_BGEU, CORE_ENC_OP_ANDI, CORE_ENC_OP_AND,
            CORE_ENC_OP_CSRRCI:                                             f3 = F3_111;
            default: ;
        endcase
    end

    // Format assembly and immediate error flag for all single-word ops.
    always_comb begin
        enc_inst = NOP_INST;
        enc_err  = 1'b0;
        case (i_cmd_op)
            CORE_ENC_OP_LUI: begin
                enc_inst = {i_cmd_imm[31:12], i_cmd_rd, OPC_LUI};
                enc_err  = ~imm_u_ok;
            end
            CORE_ENC_OP_AUIPC: begin
                enc_inst = {i_cmd_imm[31:12], i_cmd_rd, OPC_AUIPC};
                enc_err  = ~imm_u_ok;
            end
            CORE_ENC_OP_JAL: begin
                enc_inst = {i_cmd_imm[20], i_cmd_imm[10:1], i_cmd_imm[11],
                            i_cmd_imm[19:12], i_cmd_rd, OPC_JAL};
                enc_err  = ~imm_j_ok;
            end
            CORE_ENC_OP_JALR: begin
                enc_inst = {i_fields, OPC_JALR};
                enc_err  = ~imm_i_ok;
            end
            CORE_ENC_OP_BEQ, CORE_ENC_OP_BNE, CORE_ENC_OP_BLT, CORE_ENC_OP_BGE,
            CORE_ENC_OP_BLTU, CORE_ENC_OP_BGEU: begin
                enc_inst = {i_cmd_imm[12], i_cmd_imm[10:5], i_cmd_rs2, i_cmd_rs1, f3,
                            i_cmd_imm[4:1], i_cmd_imm[11], OPC_BRANCH};
                enc_err  = ~imm_b_ok;
            end
            CORE_ENC_OP_LB, CORE_ENC_OP_LH, CORE_ENC_OP_LW, CORE_ENC_OP_LBU,
            CORE_ENC_OP_LHU: begin
                enc_inst = {i_fields, OPC_LOAD};
                enc_err  = ~imm_i_ok;
            end
            CORE_ENC_OP_SB, CORE_ENC_OP_SH, CORE_ENC_OP_SW: begin
                enc_inst = {i_cmd_imm[11:5], i_cmd_rs2, i_cmd_rs1, f3,
                            i_cmd_imm[4:0], OPC_STORE};
                enc_err  = ~imm_i_ok;
            end
            CORE_ENC_OP_ADDI, CORE_ENC_OP_SLTI, CORE_ENC_OP_SLTIU, CORE_ENC_OP_XORI,
            CORE_ENC_OP_ORI, CORE_ENC_OP_ANDI: begin
                enc_inst = {i_fields, OPC_OP_IMM};
                enc_err  = ~imm_i_ok;
            end
            CORE_ENC_OP_SLLI, CORE_ENC_OP_SRLI, CORE_ENC_OP_SRAI: begin
                enc_inst = {f7, i_cmd_imm[4:0], i_cmd_rs1, f3, i_cmd_rd, OPC_OP_IMM};
                enc_err  = ~imm_sh_ok;
            end
            CORE_ENC_OP_ADD, CORE_ENC_OP_SUB, CORE_ENC_OP_SLL, CORE_ENC_OP_SLT,
            CORE_ENC_OP_SLTU, CORE_ENC_OP_XOR, CORE_ENC_OP_SRL, CORE_ENC_OP_SRA,
            CORE_ENC_OP_OR, CORE_ENC_OP_AND: begin
                enc_inst = {f7, i_cmd_rs2, i_cmd_rs1, f3, i_cmd_rd, OPC_OP};
            end
            CORE_ENC_OP_FENCE:   enc_inst = {i_fields, OPC_MISC_MEM};
            CORE_ENC_OP_FENCE_I: enc_inst = {12'd0, 5'd0, f3, 5'd0, OPC_MISC_MEM};
            CORE_ENC_OP_ECALL:   enc_inst = ECALL_INST;
            CORE_ENC_OP_EBREAK:  enc_inst = EBREAK_INST;
            CORE_ENC_OP_CSRRW, CORE_ENC_OP_CSRRS, CORE_ENC_OP_CSRRC,
            CORE_ENC_OP_CSRRWI, CORE_ENC_OP_CSRRSI, CORE_ENC_OP_CSRRCI: begin
                enc_inst = {i_fields, OPC_SYSTEM};
            end
            default: begin
                enc_inst = NOP_INST;
                enc_err  = 1'b1;
            end
        endcase
    end

`ifdef CORE_INST_ENC_LI_EN
    enc_state_e  state;
    logic [4:0]  li_rd;
    logic [11:0] li_lo;
    logic [19:0] li_hi;
    logic        li_cmd;

    // Rounded upper part so that LUI + sign-extended ADDI reproduces imm.
    assign li_hi       = i_cmd_imm[31:12] + 20'(i_cmd_imm[11]);
    assign li_cmd      = (i_cmd_op == CORE_ENC_OP_LI);
    assign o_cmd_ready = (state == ST_IDLE) & ~fifo_full;
    assign cmd_fire    = i_cmd_valid & o_cmd_ready;

    // Push selection: pending LI low half, LI first word, or a normal op.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (state == ST_LI_LO) begin
            push      = ~fifo_full;
            push_word = {1'b0, li_lo, li_rd, F3_000, li_rd, OPC_OP_IMM};
        end else if (cmd_fire) begin
            push = 1'b1;
            if (li_cmd && imm_i_ok) begin
                push_word = {1'b0, i_cmd_imm[11:0], 5'd0, F3_000, i_cmd_rd, OPC_OP_IMM};
            end else if (li_cmd) begin
                push_word = {1'b0, li_hi, i_cmd_rd, OPC_LUI};
            end else begin
                push_word = {enc_err, enc_inst};
            end
        end
    end

    // LI sequencer: hold the low half until the FIFO can take it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            li_rd <= '0;
            li_lo <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire && li_cmd && !imm_i_ok) begin
                        li_rd <= i_cmd_rd;
                        li_lo <= i_cmd_imm[11:0];
                        state <= ST_LI_LO;
                    end
                end
                ST_LI_LO: begin
                    if (!fifo_full) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign o_cmd_ready = ~fifo_full;
    assign cmd_fire    = i_cmd_valid & o_cmd_ready;
    assign push        = cmd_fire;
    assign push_word   = {enc_err, enc_inst};
`endif

    assign pop        = o_inst_valid & i_inst_ready;
    assign o_inst     = head[31:0];
    assign o_inst_err = head[32];

    core_inst_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENC_WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .data      (head),
        .valid     (o_inst_valid),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_core_inst_encoder.sv
// Directed bench for core_inst_encoder with a short back-pressured random phase.
module tb_core_inst_encoder;
    import core_inst_encoder_pkg::*;

    logic        clk;
    logic        rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [5:0]  i_cmd_op;
    logic [4:0]  i_cmd_rd;
    logic [4:0]  i_cmd_rs1;
    logic [4:0]  i_cmd_rs2;
    logic [31:0] i_cmd_imm;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic        o_inst_err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    localparam int RAND_N = 40;

    core_inst_encoder #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_op     (i_cmd_op),
        .i_cmd_rd     (i_cmd_rd),
        .i_cmd_rs1    (i_cmd_rs1),
        .i_cmd_rs2    (i_cmd_rs2),
        .i_cmd_imm    (i_cmd_imm),
        .o_inst_valid (o_inst_valid),
        .i_inst_ready (i_inst_ready),
        .o_inst       (o_inst),
        .o_inst_err   (o_inst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        int   guard;
        logic fire;
        i_cmd_op    = op;
        i_cmd_rd    = rd;
        i_cmd_rs1   = rs1;
        i_cmd_rs2   = rs2;
        i_cmd_imm   = imm;
        i_cmd_valid = 1'b1;
        guard       = 0;
        do begin
            fire = o_cmd_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!fire && guard < 50);
        i_cmd_valid = 1'b0;
        if (!fire) timeout_fail("send");
    endtask

    task automatic expect_word(input string tag, input logic [31:0] inst, input logic err);
        int guard;
        guard = 0;
        while (!o_inst_valid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!o_inst_valid) begin
            timeout_fail(tag);
        end else begin
            chk({tag, "_inst"}, 72'(o_inst), 72'(inst));
            chk({tag, "_err"}, 72'(o_inst_err), 72'(err));
            i_inst_ready = 1'b1;
            @(posedge clk);
            #1;
            i_inst_ready = 1'b0;
        end
    endtask

    // Field view of a word: {err, opcode, funct3, funct7, rd, rs1, rs2, imm}.
    function automatic logic [71:0] decode(input logic err, input logic [31:0] w);
        logic [2:0]  d_f3;
        logic [6:0]  d_f7;
        logic [4:0]  d_rd;
        logic [4:0]  d_rs2;
        logic [31:0] d_imm;
        d_f3  = w[14:12];
        d_f7  = 7'd0;
        d_rd  = 5'd0;
        d_rs2 = 5'd0;
        d_imm = 32'd0;
        case (w[6:0])
            7'h13: begin
                d_rd  = w[11:7];
                d_imm = {{20{w[31]}}, w[31:20]};
            end
            7'h33: begin
                d_rd  = w[11:7];
                d_rs2 = w[24:20];
                d_f7  = w[31:25];
            end
            7'h23: begin
                d_rs2 = w[24:20];
                d_imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'h63: begin
                d_rs2 = w[24:20];
                d_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            default: ;
        endcase
        return {7'd0, err, w[6:0], d_f3, d_f7, d_rd, w[19:15], d_rs2, d_imm};
    endfunction

    function automatic logic [71:0] fields(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        return {7'd0, 1'b0, opc, f3, f7, rd, rs1, rs2, imm};
    endfunction

    logic [71:0] exp_q[$];
    logic [31:0] got[$];
    logic        accepted;
    logic        fire5;

    initial begin
        rst          = 1'b1;
        i_cmd_valid  = 1'b0;
        i_cmd_op     = '0;
        i_cmd_rd     = '0;
        i_cmd_rs1    = '0;
        i_cmd_rs2    = '0;
        i_cmd_imm    = '0;
        i_inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", 72'(o_inst_valid), 72'd0);
        chk("rst_inst", 72'(o_inst), 72'd0);
        chk("rst_err", 72'(o_inst_err), 72'd0);
        chk("rst_ready", 72'(o_cmd_ready), 72'd1);

        // ADDI x1, x2, -1 with one-cycle latency
        send(CORE_ENC_OP_ADDI, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
        chk("addi_latency", 72'(o_inst_valid), 72'd1);
        expect_word("addi", 32'hFFF1_0093, 1'b0);

`ifdef CORE_INST_ENC_LI_EN
        send(CORE_ENC_OP_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        chk("li_ready_gap", 72'(o_cmd_ready), 72'd0);
        @(posedge clk);
        #1;
        chk("li_ready_back", 72'(o_cmd_ready), 72'd1);
        expect_word("li_lui", 32'h1234_62B7, 1'b0);
        expect_word("li_addi", 32'hFFF2_8293, 1'b0);
        send(CORE_ENC_OP_LI, 5'd3, 5'd0, 5'd0, 32'hFFFF_FFFB);
        chk("li_small_ready", 72'(o_cmd_ready), 72'd1);
        expect_word("li_small", 32'hFFB0_0193, 1'b0);
`else
        send(CORE_ENC_OP_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        expect_word("li_undef", 32'h0000_0013, 1'b1);
`endif

        send(CORE_ENC_OP_JAL, 5'd1, 5'd0, 5'd0, 32'h0000_0801);
        expect_word("jal_odd", 32'h0010_00EF, 1'b1);
        send(CORE_ENC_OP_BEQ, 5'd0, 5'd1, 5'd2, 32'h0000_1000);
        expect_word("beq_range", 32'h8020_8063, 1'b1);
        send(CORE_ENC_OP_EBREAK, 5'd0, 5'd0, 5'd0, 32'h0);
        expect_word("ebreak", 32'h0010_0073, 1'b0);
        send(CORE_ENC_OP_SW, 5'd0, 5'd2, 5'd3, 32'h0000_0008);
        expect_word("sw", 32'h0031_2423, 1'b0);
        send(CORE_ENC_OP_SRAI, 5'd4, 5'd4, 5'd0, 32'h0000_0003);
        expect_word("srai", 32'h4032_5213, 1'b0);
        send(CORE_ENC_OP_SLLI, 5'd1, 5'd1, 5'd0, 32'h0000_0020);
        expect_word("slli_shamt", 32'h0000_9093, 1'b1);
        send(CORE_ENC_OP_SUB, 5'd3, 5'd1, 5'd2, 32'h0);
        expect_word("sub", 32'h4020_81B3, 1'b0);
        send(CORE_ENC_OP_LUI, 5'd1, 5'd0, 5'd0, 32'h1234_5000);
        expect_word("lui", 32'h1234_50B7, 1'b0);
        send(CORE_ENC_OP_LUI, 5'd1, 5'd0, 5'd0, 32'h1234_5001);
        expect_word("lui_low", 32'h1234_50B7, 1'b1);
        send(CORE_ENC_OP_CSRRWI, 5'd1, 5'd5, 5'd0, 32'h0000_0300);
        expect_word("csrrwi", 32'h3002_D0F3, 1'b0);
        send(6'd63, 5'd1, 5'd1, 5'd1, 32'h0);
        expect_word("undef_op", 32'h0000_0013, 1'b1);
        send(CORE_ENC_OP_ADDI, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        expect_word("addi_2048", 32'h8000_0093, 1'b1);

        // Fill the FIFO, hold a fifth command, then drain
        for (int k = 1; k <= 4; k++) begin
            send(CORE_ENC_OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(k));
        end
        chk("full_ready_low", 72'(o_cmd_ready), 72'd0);
        i_cmd_op    = CORE_ENC_OP_ADDI;
        i_cmd_rd    = 5'd1;
        i_cmd_rs1   = 5'd0;
        i_cmd_rs2   = 5'd0;
        i_cmd_imm   = 32'd5;
        i_cmd_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("full_hold_ready", 72'(o_cmd_ready), 72'd0);
        chk("full_head_stable", 72'(o_inst), 72'h0010_0093);
        i_inst_ready = 1'b1;
        chk("full_pop_ready", 72'(o_cmd_ready), 72'd0);
        accepted = 1'b0;
        for (int c = 0; c < 20 && got.size() < 5; c++) begin
            fire5 = i_cmd_valid && o_cmd_ready;
            if (o_inst_valid) got.push_back(o_inst);
            @(posedge clk);
            #1;
            if (fire5) begin
                i_cmd_valid = 1'b0;
                accepted    = 1'b1;
            end
        end
        chk("drain_no_dup", 72'(o_inst_valid), 72'd0);
        i_inst_ready = 1'b0;
        i_cmd_valid  = 1'b0;
        chk("drain_count", 72'(got.size()), 72'd5);
        chk("fifth_accepted", 72'(accepted), 72'd1);
        for (int k = 0; k < got.size(); k++) begin
            chk($sformatf("drain_%0d", k), 72'(got[k]), 72'((32'(k + 1) << 20) | 32'h93));
        end

        // Reset while a command's follow-up is still in flight
`ifdef CORE_INST_ENC_LI_EN
        send(CORE_ENC_OP_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
`else
        send(CORE_ENC_OP_ADDI, 5'd5, 5'd0, 5'd0, 32'h1);
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", 72'(o_inst_valid), 72'd0);
        chk("mid_rst_ready", 72'(o_cmd_ready), 72'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_addi", 72'(o_inst_valid), 72'd0);
        chk("mid_rst_inst", 72'(o_inst), 72'd0);

        // Random legal commands under toggling back-pressure
        fork
            begin : producer
                for (int i = 0; i < RAND_N; i++) begin
                    logic [4:0]  rd;
                    logic [4:0]  rs1;
                    logic [4:0]  rs2;
                    logic [31:0] imm;
                    int          kind;
                    int          guard;
                    logic        fire;
                    rd   = 5'($urandom_range(0, 31));
                    rs1  = 5'($urandom_range(0, 31));
                    rs2  = 5'($urandom_range(0, 31));
                    imm  = 32'($urandom_range(0, 4095)) - 32'd2048;
                    kind = $urandom_range(0, 3);
                    case (kind)
                        0: begin
                            i_cmd_op = CORE_ENC_OP_ADDI;
                            exp_q.push_back(fields(7'h13, 3'd0, 7'd0, rd, rs1, 5'd0, imm));
                        end
                        1: begin
                            if (imm[0]) begin
                                i_cmd_op = CORE_ENC_OP_SUB;
                                exp_q.push_back(fields(7'h33, 3'd0, 7'h20, rd, rs1, rs2, 32'd0));
                            end else begin
                                i_cmd_op = CORE_ENC_OP_ADD;
                                exp_q.push_back(fields(7'h33, 3'd0, 7'h00, rd, rs1, rs2, 32'd0));
                            end
                        end
                        2: begin
                            i_cmd_op = CORE_ENC_OP_SW;
                            exp_q.push_back(fields(7'h23, 3'd2, 7'd0, 5'd0, rs1, rs2, imm));
                        end
                        default: begin
                            imm = imm << 1;
                            if (rd[0]) begin
                                i_cmd_op = CORE_ENC_OP_BNE;
                                exp_q.push_back(fields(7'h63, 3'd1, 7'd0, 5'd0, rs1, rs2, imm));
                            end else begin
                                i_cmd_op = CORE_ENC_OP_BEQ;
                                exp_q.push_back(fields(7'h63, 3'd0, 7'd0, 5'd0, rs1, rs2, imm));
                            end
                        end
                    endcase
                    i_cmd_rd    = rd;
                    i_cmd_rs1   = rs1;
                    i_cmd_rs2   = rs2;
                    i_cmd_imm   = imm;
                    i_cmd_valid = 1'b1;
                    guard       = 0;
                    do begin
                        fire = o_cmd_ready;
                        @(posedge clk);
                        #1;
                        guard++;
                    end while (!fire && guard < 100);
                    i_cmd_valid = 1'b0;
                    if (!fire) timeout_fail("rand_send");
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin : consumer
                int n_got;
                n_got = 0;
                for (int c = 0; c < 3000 && n_got < RAND_N; c++) begin
                    i_inst_ready = 1'($urandom_range(0, 1));
                    if (o_inst_valid && i_inst_ready) begin
                        if (exp_q.size() == 0) begin
                            timeout_fail("rand_extra_word");
                        end else begin
                            chk($sformatf("rand_%0d", n_got), decode(o_inst_err, o_inst),
                                exp_q.pop_front());
                        end
                        n_got++;
                    end
                    @(posedge clk);
                    #1;
                end
                i_inst_ready = 1'b0;
                if (n_got < RAND_N) timeout_fail("rand_drain");
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("rand_no_extra", 72'(o_inst_valid), 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_inst_encoder.md
# core_inst_encoder

RV32I instruction encoder for the debug/test instruction-injection path. It accepts structured instruction commands (operation code, register indices, immediate) over a valid/ready handshake and encodes each one into a 32-bit RV32I instruction word. Encoded words are buffered in a small FIFO and presented on a valid/ready stream that feeds the ID stage. Every emitted word must decode in the ID-stage decoder back to the commanded instruction, register indices and immediate.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when valid & ready
- i_cmd_op  in  6  operation code, `CORE_ENC_OP_*`
- i_cmd_rd / i_cmd_rs1 / i_cmd_rs2  in  5 each  register indices; rs1 carries zimm for CSR-immediate ops
- i_cmd_imm  in  32  full immediate value (CSR address in [11:0] for CSR ops)
- o_inst_valid  out  1  word available
- i_inst_ready  in  1  consumer takes word when valid & ready
- o_inst  out  32  encoded instruction
- o_inst_err  out  1  word was encoded from an illegal command or an out-of-range immediate

## Operation
- Ops: LUI, AUIPC, JAL, JALR, BEQ–BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, ADDI–SRAI, ADD–AND, FENCE, FENCE_I, ECALL, EBREAK, CSRRW–CSRRCI, LI (pseudo).
- Immediate checks, err=1 on failure, word still encoded from truncated bits:
  - I/S: signed 12-bit.
  - B: signed 13-bit with bit0=0.
  - J: signed 21-bit with bit0=0.
  - U: imm[11:0]=0; the field is imm[31:12].
  - Shifts: imm[31:5]=0; SRAI/SRA set funct7=0100000.
- Undefined op code: o_inst=32'h0000_0013 (NOP), err=1.
- FSM states: IDLE and LI_LO.
  - IDLE: accepting a normal op pushes one word and stays in IDLE.
  - IDLE: accepting LI whose imm fits signed 12 bits pushes ADDI rd,x0,imm and stays in IDLE.
  - IDLE: accepting any other LI pushes LUI rd,(imm+0x800)>>12, latches rd and imm[11:0], and moves to LI_LO.
  - LI_LO: pushes ADDI rd,rd,imm[11:0] when the FIFO has space, then returns to IDLE.
- o_cmd_ready = (state==IDLE) & (count<DEPTH).
- At most one push per cycle.
- FIFO stores {err, inst}. Read and write pointers are log2(DEPTH)+1 bits; wrap-around is natural.

## Timing
- Reset values: o_inst_valid=0, o_inst=0, o_inst_err=0, o_cmd_ready=1, FIFO empty, state IDLE.
- Latency: a command accepted in cycle N makes its word valid in cycle N+1 when the FIFO was empty. The second LI word follows no earlier than cycle N+2.
- No combinational path from i_cmd_* to o_inst*. o_cmd_ready does not depend on i_inst_ready in the same cycle.
- Simultaneous push and pop: count is unchanged. A full FIFO with a pop in the same cycle still holds o_cmd_ready=0.
- Pop on empty and push on full are impossible by construction; the assertions below cover them.
- o_inst and o_inst_err are stable while o_inst_valid & !i_inst_ready.
- Reset asserted mid-LI discards the pending ADDI and all FIFO contents.

## Configuration
- CORE_INST_ENC_LI_EN defined: the LI pseudo-op and the LI_LO state are built.
- Without the macro: LI is an undefined op (NOP, err=1), the FSM is absent, and o_cmd_ready = (count<DEPTH).

## Structure
- Shared package/defines file holds:
  - `CORE_ENC_OP_*` codes and the op width.
  - Opcode constants (LUI 0110111, OP-IMM 0010011, SYSTEM 1110011, …).
  - funct3/funct7 constants.
- One sub-module, core_inst_enc_fifo: parameterised DEPTH, width 33, registered output.
- Encode logic and FSM live in core_inst_encoder.
- Assertions: no push when full, no pop when empty.

## Test plan
- ADDI rd=1, rs1=2, imm=-1 -> o_inst=0xFFF10093, err=0, valid one cycle after accept.
- LI rd=5, imm=0x12345FFF -> 0x123462B7 then 0xFFF28293; o_cmd_ready=0 for the cycle in between.
- JAL imm=0x801, then BEQ imm=4096 -> both words err=1. EBREAK -> 0x00100073, err=0.
- DEPTH=4, i_inst_ready=0, push 4 ADDIs -> o_cmd_ready=0; 5th command held. Raise ready -> 4 words drain in order, then the 5th is accepted.
- Assert rst in the cycle after LI accept -> no ADDI emitted, o_inst_valid=0, o_cmd_ready=1 after release.
- Random legal commands with full-rate back-pressure toggling -> each word decodes to the commanded op, indices and imm; no loss or duplication.
